// File: rtl/dit_fft_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dit_fft_stream                                                  |
// | Purpose  : Streaming radix-2 DIT FFT/IFFT, in-place, one butterfly/clock.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dit_fft_stream #(
    parameter int N         = 8,
    parameter int W         = 16,
    parameter int FRAC      = 12,
    parameter int SCALE_FFT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [W-1:0]     in_re,
    input  logic signed [W-1:0]     in_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [W-1:0]     out_re,
    output logic signed [W-1:0]     out_im,
    output logic [$clog2(N)-1:0]    out_idx,
    output logic                    out_last,
    output logic                    busy,
    output logic                    ovf
);

    localparam int c_LOG2N = $clog2(N);
    localparam int c_BFW   = c_LOG2N - 1;
    localparam int c_PW    = 2 * W + 2;
    localparam int c_QMAX  = (1 << (W - 1)) - 1;
    localparam int c_QMIN  = -(1 << (W - 1));
    localparam real c_PI   = 3.14159265358979323846;

    localparam logic [c_LOG2N-1:0]      c_LAST_IDX   = c_LOG2N'(N - 1);
    localparam logic [c_LOG2N-1:0]      c_STAGE_LAST = c_LOG2N'(c_LOG2N - 1);
    localparam logic [c_BFW-1:0]        c_BF_LAST    = {c_BFW{1'b1}};
    localparam logic signed [c_PW-1:0]  c_MAXV       = (c_PW'(1) <<< (W - 1)) - c_PW'(1);
    localparam logic signed [c_PW-1:0]  c_MINV       = ~c_MAXV;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_UNLOAD  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_mode;
    logic [c_LOG2N-1:0]     r_cnt;
    logic [c_LOG2N-1:0]     r_stage;
    logic [c_BFW-1:0]       r_bf;
    logic signed [W-1:0]    r_mem_re [N];
    logic signed [W-1:0]    r_mem_im [N];

    // Twiddle table: cos and sin of 2*pi*k/N, rounded to nearest at FRAC bits.
    logic signed [W-1:0]    w_cos_tab [N];
    logic signed [W-1:0]    w_sin_tab [N];

    for (genvar k = 0; k < N; k++) begin : g_twiddle
        localparam real c_ANG = 2.0 * c_PI * k / N;
        localparam real c_CR  = $cos(c_ANG) * (1 << FRAC);
        localparam real c_SR  = $sin(c_ANG) * (1 << FRAC);
        localparam int  c_CQ  = (c_CR >= 0.0) ? $rtoi(c_CR + 0.5) : -$rtoi(0.5 - c_CR);
        localparam int  c_SQ  = (c_SR >= 0.0) ? $rtoi(c_SR + 0.5) : -$rtoi(0.5 - c_SR);
        localparam int  c_CS  = (c_CQ > c_QMAX) ? c_QMAX : ((c_CQ < c_QMIN) ? c_QMIN : c_CQ);
        localparam int  c_SS  = (c_SQ > c_QMAX) ? c_QMAX : ((c_SQ < c_QMIN) ? c_QMIN : c_SQ);
        assign w_cos_tab[k] = c_CS[W-1:0];
        assign w_sin_tab[k] = c_SS[W-1:0];
    end

    function automatic logic [c_LOG2N-1:0] bitrev(input logic [c_LOG2N-1:0] v);
        logic [c_LOG2N-1:0] r;
        for (int i = 0; i < c_LOG2N; i++) r[i] = v[c_LOG2N-1-i];
        return r;
    endfunction

    // Returns {saturated_flag, clipped_value}.
    function automatic logic [W:0] saturate(input logic signed [c_PW-1:0] v);
        if (v > c_MAXV)      return {1'b1, c_MAXV[W-1:0]};
        else if (v < c_MINV) return {1'b1, c_MINV[W-1:0]};
        else                 return {1'b0, v[W-1:0]};
    endfunction

    // Butterfly addressing: group base = (j with low s bits cleared) << 1.
    logic [c_LOG2N-1:0] w_bf_ext, w_half, w_mask, w_pos, w_addr_a, w_addr_b, w_tw_idx;

    assign w_bf_ext = {1'b0, r_bf};
    assign w_half   = c_LOG2N'(1) << r_stage;
    assign w_mask   = w_half - c_LOG2N'(1);
    assign w_pos    = w_bf_ext & w_mask;
    assign w_addr_a = ((w_bf_ext & ~w_mask) << 1) | w_pos;
    assign w_addr_b = w_addr_a | w_half;
    assign w_tw_idx = w_pos << (c_LOG2N - 1 - int'(r_stage));

    logic signed [W-1:0]    w_a_re, w_a_im, w_b_re, w_b_im, w_c, w_s;
    logic signed [2*W-1:0]  w_p_rc, w_p_is, w_p_ic, w_p_rs;
    logic signed [c_PW-1:0] w_t_re_full, w_t_im_full, w_t_re, w_t_im;
    logic signed [c_PW-1:0] w_a_re_ext, w_a_im_ext;
    logic signed [c_PW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
    logic signed [c_PW-1:0] w_sum_re_s, w_sum_im_s, w_dif_re_s, w_dif_im_s;
    logic [W:0]             w_sat_sr, w_sat_si, w_sat_dr, w_sat_di;
    logic                   w_scale, w_sat_any, w_accept;
    logic [c_LOG2N-1:0]     w_next_idx;

    assign w_a_re = r_mem_re[w_addr_a];
    assign w_a_im = r_mem_im[w_addr_a];
    assign w_b_re = r_mem_re[w_addr_b];
    assign w_b_im = r_mem_im[w_addr_b];
    assign w_c    = w_cos_tab[w_tw_idx];
    assign w_s    = w_sin_tab[w_tw_idx];

    assign w_p_rc = w_b_re * w_c;
    assign w_p_is = w_b_im * w_s;
    assign w_p_ic = w_b_im * w_c;
    assign w_p_rs = w_b_re * w_s;

    // FFT twiddle is c - js; IFFT uses the conjugate c + js.
    assign w_t_re_full = r_mode ? (w_p_rc - w_p_is) : (w_p_rc + w_p_is);
    assign w_t_im_full = r_mode ? (w_p_ic + w_p_rs) : (w_p_ic - w_p_rs);
    assign w_t_re      = w_t_re_full >>> FRAC;
    assign w_t_im      = w_t_im_full >>> FRAC;

    assign w_a_re_ext = w_a_re;
    assign w_a_im_ext = w_a_im;
    assign w_sum_re   = w_a_re_ext + w_t_re;
    assign w_sum_im   = w_a_im_ext + w_t_im;
    assign w_dif_re   = w_a_re_ext - w_t_re;
    assign w_dif_im   = w_a_im_ext - w_t_im;

    assign w_scale    = r_mode || (SCALE_FFT != 0);
    assign w_sum_re_s = w_scale ? (w_sum_re >>> 1) : w_sum_re;
    assign w_sum_im_s = w_scale ? (w_sum_im >>> 1) : w_sum_im;
    assign w_dif_re_s = w_scale ? (w_dif_re >>> 1) : w_dif_re;
    assign w_dif_im_s = w_scale ? (w_dif_im >>> 1) : w_dif_im;

    assign w_sat_sr  = saturate(w_sum_re_s);
    assign w_sat_si  = saturate(w_sum_im_s);
    assign w_sat_dr  = saturate(w_dif_re_s);
    assign w_sat_di  = saturate(w_dif_im_s);
    assign w_sat_any = w_sat_sr[W] | w_sat_si[W] | w_sat_dr[W] | w_sat_di[W];

    assign w_accept   = in_valid && in_ready;
    assign w_next_idx = out_idx + c_LOG2N'(1);

    // Sample memory: never reset, contents are overwritten by each new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_accept) begin
                r_mem_re[bitrev(r_cnt)] <= in_re;
                r_mem_im[bitrev(r_cnt)] <= in_im;
            end else if (r_state == ST_COMPUTE) begin
                r_mem_re[w_addr_a] <= w_sat_sr[W-1:0];
                r_mem_im[w_addr_a] <= w_sat_si[W-1:0];
                r_mem_re[w_addr_b] <= w_sat_dr[W-1:0];
                r_mem_im[w_addr_b] <= w_sat_di[W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_mode    <= 1'b0;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_bf      <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (w_accept) begin
                        if (r_state == ST_IDLE) begin
                            r_mode <= mode;
                            ovf    <= 1'b0;
                            busy   <= 1'b1;
                        end
                        r_cnt <= r_cnt + c_LOG2N'(1);
                        if (r_cnt == c_LAST_IDX) begin
                            r_state  <= ST_COMPUTE;
                            in_ready <= 1'b0;
                            r_stage  <= '0;
                            r_bf     <= '0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_COMPUTE: begin
                    if (w_sat_any) ovf <= 1'b1;
                    if (r_bf == c_BF_LAST) begin
                        r_bf <= '0;
                        if (r_stage == c_STAGE_LAST) begin
                            // Bin 0 is final here: the last butterfly touches only N/2-1 and N-1.
                            r_state   <= ST_UNLOAD;
                            out_valid <= 1'b1;
                            out_re    <= r_mem_re[0];
                            out_im    <= r_mem_im[0];
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                        end else begin
                            r_stage <= r_stage + c_LOG2N'(1);
                        end
                    end else begin
                        r_bf <= r_bf + c_BFW'(1);
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (out_last) begin
                            r_state   <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_re    <= '0;
                            out_im    <= '0;
                            out_idx   <= '0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                        end else begin
                            out_idx  <= w_next_idx;
                            out_re   <= r_mem_re[w_next_idx];
                            out_im   <= r_mem_im[w_next_idx];
                            out_last <= (w_next_idx == c_LAST_IDX);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dit_fft_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dit_fft_stream                                               |
// | Purpose  : Directed + random frames checked against a reference DFT model. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dit_fft_stream;

    localparam int N         = 8;
    localparam int W         = 16;
    localparam int FRAC      = 12;
    localparam int SCALE_FFT = 0;
    localparam int LOGN      = 3;
    localparam real PI       = 3.14159265358979323846;

    logic clk = 1'b0;
    logic reset = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, out_last, busy, ovf;
    logic signed [W-1:0] in_re = '0, in_im = '0;
    logic signed [W-1:0] out_re, out_im;
    logic [LOGN-1:0] out_idx;

    int n_pass = 0, n_total = 0;
    int cyc = 0, last_cyc = 0;
    longint x_re[N], x_im[N], e_re[N], e_im[N];
    bit e_ovf;

    dit_fft_stream #(.N(N), .W(W), .FRAC(FRAC), .SCALE_FFT(SCALE_FFT)) dut (
        .clk(clk), .reset(reset), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic longint quant(input real v);
        real s;
        longint q;
        s = v * (1 << FRAC);
        q = (s >= 0.0) ? longint'($rtoi(s + 0.5)) : -longint'($rtoi(0.5 - s));
        if (q > 32767) q = 32767;
        return q;
    endfunction

    function automatic longint sat(input longint v);
        if (v > 32767)  begin e_ovf = 1'b1; return 32767;  end
        if (v < -32768) begin e_ovf = 1'b1; return -32768; end
        return v;
    endfunction

    function automatic int brev(input int v);
        int r = 0;
        for (int b = 0; b < LOGN; b++) if ((v & (1 << b)) != 0) r |= 1 << (LOGN - 1 - b);
        return r;
    endfunction

    // Textbook iterative DIT over a bit-reversed copy, with fixed-point rules applied.
    task automatic ref_model(input bit m);
        longint ar[N], ai[N];
        longint wr, wi, br, bi, tr, ti, ur, ui, vr, vi;
        bit sc;
        int k, ia, ib;
        sc = m || (SCALE_FFT != 0);
        e_ovf = 1'b0;
        for (int n = 0; n < N; n++) begin
            ar[brev(n)] = x_re[n];
            ai[brev(n)] = x_im[n];
        end
        for (int len = 2; len <= N; len *= 2) begin
            for (int st = 0; st < N; st += len) begin
                for (int j = 0; j < len / 2; j++) begin
                    k  = j * (N / len);
                    wr = quant($cos(2.0 * PI * k / N));
                    wi = m ? quant($sin(2.0 * PI * k / N)) : -quant($sin(2.0 * PI * k / N));
                    ia = st + j;
                    ib = st + j + len / 2;
                    br = ar[ib];
                    bi = ai[ib];
                    tr = (br * wr - bi * wi) >>> FRAC;
                    ti = (br * wi + bi * wr) >>> FRAC;
                    ur = ar[ia] + tr;  ui = ai[ia] + ti;
                    vr = ar[ia] - tr;  vi = ai[ia] - ti;
                    if (sc) begin
                        ur = ur >>> 1; ui = ui >>> 1; vr = vr >>> 1; vi = vi >>> 1;
                    end
                    ar[ia] = sat(ur); ai[ia] = sat(ui);
                    ar[ib] = sat(vr); ai[ib] = sat(vi);
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            e_re[n] = ar[n];
            e_im[n] = ai[n];
        end
    endtask

    task automatic set_const(input longint re_v);
        for (int n = 0; n < N; n++) begin
            e_re[n] = re_v;
            e_im[n] = 0;
        end
        e_ovf = 1'b0;
    endtask

    task automatic set_x_zero();
        for (int n = 0; n < N; n++) begin
            x_re[n] = 0;
            x_im[n] = 0;
        end
    endtask

    task automatic set_x_rand(input int amp);
        for (int n = 0; n < N; n++) begin
            x_re[n] = longint'($urandom_range(0, 2 * amp)) - amp;
            x_im[n] = longint'($urandom_range(0, 2 * amp)) - amp;
        end
    endtask

    // Sends x[] in natural order; mode flips to ~m from sample index tog onward.
    task automatic send_frame(input bit m, input int tog);
        int guard;
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("ovf_cleared_on_first_sample", ovf, 0);
                check("busy_in_load", busy, 1);
            end
            in_valid = 1'b1;
            in_re    = W'(x_re[n]);
            in_im    = W'(x_im[n]);
            mode     = (n >= tog) ? ~m : m;
            guard    = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        last_cyc = cyc;
    endtask

    task automatic collect(input bit stall, input bit rnd);
        int got_cnt = 0, stall_left = 5, guard = 0, lat = -1;
        bit done = 1'b0, idle_checked = 1'b0;
        while (!done && guard < 500) begin
            @(negedge clk);
            guard++;
            if (!out_valid) begin
                if (!idle_checked) begin
                    check("out_zero_when_invalid", {out_re, out_im}, 0);
                    idle_checked = 1'b1;
                end
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                if (lat < 0) begin
                    lat = cyc - last_cyc;
                    check("first_output_latency", lat, 12);
                end
                if (stall && out_idx == 3 && stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    check("stall_hold_idx", out_idx, 3);
                    check("stall_hold_re", out_re, e_re[3]);
                    check("stall_hold_im", out_im, e_im[3]);
                end else begin
                    out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    if (out_ready) begin
                        check("bin_idx", out_idx, got_cnt);
                        check("bin_re", out_re, e_re[got_cnt]);
                        check("bin_im", out_im, e_im[got_cnt]);
                        check("bin_last", out_last, (got_cnt == N - 1) ? 1 : 0);
                        got_cnt++;
                        if (out_last) done = 1'b1;
                    end
                end
            end
        end
        if (!done) check("unload_timeout", 0, 1);
        check("bins_delivered", got_cnt, N);
        if (stall) check("stall_cycles_used", stall_left, 0);
        @(negedge clk);
        out_ready = 1'b0;
        check("post_in_ready", in_ready, 1);
        check("post_out_valid", out_valid, 0);
        check("post_busy", busy, 0);
        check("post_out_zero", {out_re, out_im}, 0);
        check("frame_ovf", ovf, e_ovf);
    endtask

    initial begin
        bit bad;
        bit m;

        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", {out_re, out_im}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);

        // FFT of a unit impulse is flat.
        set_x_zero();
        x_re[0] = 4096;
        set_const(4096);
        send_frame(1'b0, N);
        collect(1'b0, 1'b0);

        // IFFT of DC bin spreads 1/N of it across every sample.
        set_x_zero();
        x_re[0] = 16384;
        set_const(2048);
        send_frame(1'b1, N);
        collect(1'b0, 1'b0);

        set_x_rand(2048);
        ref_model(1'b0);
        send_frame(1'b0, N);
        collect(1'b1, 1'b0);

        // Constant 0x2000 input overflows bin 0.
        for (int n = 0; n < N; n++) begin
            x_re[n] = 8192;
            x_im[n] = 0;
        end
        ref_model(1'b0);
        send_frame(1'b0, N);
        collect(1'b0, 1'b0);
        check("ovf_X0_saturated_model", e_re[0], 32767);
        repeat (3) @(negedge clk);
        check("ovf_sticky_idle", ovf, 1);

        set_x_rand(4096);
        ref_model(1'b0);
        send_frame(1'b0, 4);
        collect(1'b0, 1'b1);

        // Abort a frame in the middle of the butterfly phase.
        set_x_rand(4096);
        send_frame(1'b1, N);
        repeat (4) @(negedge clk);
        check("abort_busy_before", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_release_in_ready", in_ready, 1);
        bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) bad = 1'b1;
        end
        check("abort_no_output", bad, 0);

        for (int f = 0; f < 6; f++) begin
            m = 1'($urandom_range(0, 1));
            set_x_rand(4096);
            ref_model(m);
            send_frame(m, $urandom_range(1, N));
            collect(1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
